// File: rtl/acc_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// acc_exec_ctrl_if
//   Handshaked instruction/data memory bus between the accumulator sequencer
//   and the shared memory.
//
//   mem_req   : request, held until mem_ack
//   mem_we    : 1 = write, 0 = read (valid while mem_req)
//   mem_addr  : memory address (ADDR_W bits)
//   mem_wdata : store data
//   mem_rdata : read data, valid in the cycle mem_ack is high
//   mem_ack   : one-cycle completion strobe
//
//   master : the sequencer (acc_exec_ctrl)
//   slave  : the memory
// ---------------------------------------------------------------------------
interface acc_exec_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/acc_exec_ctrl.sv
// ---------------------------------------------------------------------------
// acc_exec_ctrl
//   Multicycle control sequencer for the 8-bit accumulator datapath.
//   Fetches an instruction over the memory bus, decodes it, fetches a memory
//   operand when needed, drives the external combinational ALU for one EXEC
//   cycle and performs stores. Owns PC, IR, ACC and the operand register.
//
//   Ports:
//     clk, rst     : clock (rising edge), asynchronous active-high reset
//     mem_if       : memory bus master (req/we/addr/wdata out, rdata/ack in)
//     alu_op       : 001 add, 010 sub, 011 and, 100 or, 000 otherwise
//     alu_en       : high only in EXEC
//     alu_operand  : operand presented to the ALU
//     alu_result   : combinational ALU result (acc op alu_operand)
//     acc, pc      : architectural accumulator and program counter
//     halted       : high once a HLT has been executed
//     zero         : z flag (only with ACC_BRANCH_EN)
//
//   Optional feature macro: ACC_BRANCH_EN
//     Adds the z flag, JMP (opcode C), JZ (opcode D) and the zero port.
//     Without it, opcodes C and D execute as NOP.
// ---------------------------------------------------------------------------
module acc_exec_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8   // opcode is [7:4], operand [3:0]: keep at 8
) (
  input  logic               clk,
  input  logic               rst,
  acc_exec_ctrl_if.master    mem_if,
  output logic [2:0]         alu_op,
  output logic               alu_en,
  output logic [DATA_W-1:0]  alu_operand,
  input  logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  acc,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
`ifdef ACC_BRANCH_EN
  ,
  output logic               zero
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_EXEC,
    S_MEM_WR,
    S_HALT
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_SUBI = 4'h6,
    OP_ANDI = 4'h7,
    OP_ORI  = 4'h8,
    OP_LDA  = 4'h9,
    OP_STA  = 4'hA,
    OP_LDI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_JZ   = 4'hD,
    OP_RSV  = 4'hE,
    OP_HLT  = 4'hF
  } opcode_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] opnd_q, opnd_d;

  opcode_t           opcode;
  logic [3:0]        imm;

  assign opcode = opcode_t'(ir_q[7:4]);
  assign imm    = ir_q[3:0];

`ifdef ACC_BRANCH_EN
  logic z_q, z_d;
  assign zero = z_q;
`endif

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values computed by the combinational block for this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
`ifdef ACC_BRANCH_EN
      z_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
`ifdef ACC_BRANCH_EN
      z_q     <= z_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and register update logic
  // -------------------------------------------------------------------------
  // NOTE: every variable gets its hold value before the case statement, so
  // paths that do not assign it cannot infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;

    unique case (state_q)
      S_FETCH: begin
        if (mem_if.mem_ack) begin
          ir_d    = mem_if.mem_rdata;
          pc_d    = pc_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LDA: state_d = S_MEM_RD;
          OP_STA:                                state_d = S_MEM_WR;
          OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI: begin
            opnd_d  = DATA_W'(imm);
            state_d = S_EXEC;
          end
          OP_LDI: begin
            acc_d   = DATA_W'(imm);
            state_d = S_FETCH;
          end
          OP_HLT:                                state_d = S_HALT;
`ifdef ACC_BRANCH_EN
          OP_JMP: begin
            pc_d    = ADDR_W'(imm);
            state_d = S_FETCH;
          end
          OP_JZ: begin
            if (z_q) pc_d = ADDR_W'(imm);
            state_d = S_FETCH;
          end
`endif
          default:                               state_d = S_FETCH;
        endcase
      end

      S_MEM_RD: begin
        if (mem_if.mem_ack) begin
          if (opcode == OP_LDA) begin
            acc_d   = mem_if.mem_rdata;
            state_d = S_FETCH;
          end else begin
            opnd_d  = mem_if.mem_rdata;
            state_d = S_EXEC;
          end
        end
      end

      S_EXEC: begin
        acc_d   = alu_result;
        state_d = S_FETCH;
      end

      S_MEM_WR: begin
        if (mem_if.mem_ack) state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase
  end

`ifdef ACC_BRANCH_EN
  // z follows only actual accumulator writes; it is not simply acc == 0,
  // because after reset acc is 0 while z is 0.
  always_comb begin
    z_d = z_q;
    if ((state_q == S_EXEC) ||
        (state_q == S_DECODE && opcode == OP_LDI) ||
        (state_q == S_MEM_RD && opcode == OP_LDA && mem_if.mem_ack))
      z_d = (acc_d == '0);
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, stable while a request waits
  // -------------------------------------------------------------------------
  always_comb begin
    // The reset state is FETCH, but no request may be visible while rst is
    // held, so a late ack during reset finds mem_req low.
    mem_if.mem_req   = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                        (state_q == S_MEM_WR)) && !rst;
    mem_if.mem_we    = (state_q == S_MEM_WR);
    mem_if.mem_addr  = (state_q == S_FETCH) ? pc_q : ADDR_W'(imm);
    mem_if.mem_wdata = acc_q;

    alu_en      = (state_q == S_EXEC);
    alu_operand = opnd_q;
    alu_op      = 3'b000;
    if (state_q == S_EXEC) begin
      case (opcode)
        OP_ADD, OP_ADDI: alu_op = 3'b001;
        OP_SUB, OP_SUBI: alu_op = 3'b010;
        OP_AND, OP_ANDI: alu_op = 3'b011;
        OP_OR,  OP_ORI:  alu_op = 3'b100;
        default:         alu_op = 3'b000;
      endcase
    end

    halted = (state_q == S_HALT);
    acc    = acc_q;
    pc     = pc_q;
  end

endmodule
